// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the register file and its users.
// Contents:
//   DATA_W   - register data width
//   ADDR_W   - register index width
//   NUM_REGS - architectural register count, including the hardwired r0
//   REG_ZERO - index of the hardwired zero register
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_if.sv
// Register-file bus: the write port, the two operand read ports, the debug
// read port and the write counter, bundled for the datapath.
// Modports:
//   master - datapath side; drives the write port and the read/debug indices
//   slave  - register-file side; returns the read data, debug data and WrCount
interface reg_file_if #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
);

    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [ADDR_W-1:0] DbgAddr;
    logic [DATA_W-1:0] DbgData;
    logic [15:0]       WrCount;

    modport master (
        output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, DbgAddr,
        input  ReadData1, ReadData2, DbgData, WrCount
    );

    modport slave (
        input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, DbgAddr,
        output ReadData1, ReadData2, DbgData, WrCount
    );

endinterface

// File: rtl/reg_file_rd_port.sv
// One read port of the register file: forces index 0 to read as zero and,
// when BYPASS is set, forwards the in-flight write data to a matching read.
// Ports:
//   addr    - read index
//   stored  - value currently held in storage at addr (don't care for addr 0)
//   wr_en   - a write will commit on the next edge (already qualified)
//   wr_addr - index of that write
//   wr_data - data of that write
//   data    - read result
module reg_file_rd_port #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data
);

    import cpu_pkg::*;

    // The zero check comes last so that r0 reads zero even when a write to
    // r0 is somehow presented as forwarded data.
    always_comb begin
        data = stored;
        if (BYPASS && wr_en && (wr_addr == addr)) begin
            data = wr_data;
        end
        if (addr == ADDR_W'(REG_ZERO)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with a hardwired zero register, optional
// write-to-read forwarding on the operand ports, an unforwarded debug read
// port and a count of committed writes.
// Ports:
//   clk   - clock, rising edge active
//   rst_n - asynchronous active-low reset; clears all registers and WrCount
//   bus   - reg_file_if slave modport (write port, read ports, debug, WrCount)
module reg_file #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_if.slave    bus
);

    import cpu_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;

    // r0 has no storage, so the array starts at index 1.
    logic [DATA_W-1:0] regs [1:DEPTH-1];
    logic [15:0]       wr_count;
    logic              wr_valid;
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;
    logic [DATA_W-1:0] stored_dbg;

    // A write is real only outside reset and when it does not target r0.
    // Gating with rst_n also keeps reset-time writes from being forwarded.
    assign wr_valid = bus.RegWrite && rst_n && (bus.WriteReg != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_valid) begin
            regs[bus.WriteReg] <= bus.WriteData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (wr_valid) begin
            wr_count <= wr_count + 16'd1;
        end
    end

    // Index 0 would fall outside the array, so it yields zero here and the
    // read ports force it to zero again.
    always_comb begin
        stored1    = '0;
        stored2    = '0;
        stored_dbg = '0;
        if (bus.ReadReg1 != ADDR_W'(REG_ZERO)) begin
            stored1 = regs[bus.ReadReg1];
        end
        if (bus.ReadReg2 != ADDR_W'(REG_ZERO)) begin
            stored2 = regs[bus.ReadReg2];
        end
        if (bus.DbgAddr != ADDR_W'(REG_ZERO)) begin
            stored_dbg = regs[bus.DbgAddr];
        end
    end

    reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd1 (
        .addr    (bus.ReadReg1),
        .stored  (stored1),
        .wr_en   (wr_valid),
        .wr_addr (bus.WriteReg),
        .wr_data (bus.WriteData),
        .data    (bus.ReadData1)
    );

    reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd2 (
        .addr    (bus.ReadReg2),
        .stored  (stored2),
        .wr_en   (wr_valid),
        .wr_addr (bus.WriteReg),
        .wr_data (bus.WriteData),
        .data    (bus.ReadData2)
    );

    // The debug port observes storage only, never in-flight writes.
    reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_rd_dbg (
        .addr    (bus.DbgAddr),
        .stored  (stored_dbg),
        .wr_en   (wr_valid),
        .wr_addr (bus.WriteReg),
        .wr_data (bus.WriteData),
        .data    (bus.DbgData)
    );

    assign bus.WrCount = wr_count;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file. Two instances share identical stimulus:
// dut_b with forwarding enabled and dut_n with it disabled.
module tb_reg_file;

    logic clk;
    logic rst_n;

    reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
    reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_n (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs plus the outputs expected at the falling edge, i.e. before the
    // write (if any) commits on the following rising edge.
    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  dbg;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ed;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [10];
    vec_t exp_q [$];

    int tests;
    int fails;

    task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic driveBoth(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                             input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
        bus_b.RegWrite = we;  bus_n.RegWrite = we;
        bus_b.WriteReg = wr;  bus_n.WriteReg = wr;
        bus_b.WriteData = wd; bus_n.WriteData = wd;
        bus_b.ReadReg1 = r1;  bus_n.ReadReg1 = r1;
        bus_b.ReadReg2 = r2;  bus_n.ReadReg2 = r2;
        bus_b.DbgAddr = dbg;  bus_n.DbgAddr = dbg;
    endtask

    task automatic applyStimulus(input vec_t v);
        driveBoth(v.we, v.wr, v.wd, v.r1, v.r2, v.dbg);
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input int idx);
        vec_t v;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL scoreboard_empty vec%0d: got 0 entries expected 1", idx);
            return;
        end
        v = exp_q.pop_front();
        compareValue($sformatf("vec%0d byp_rd1", idx), bus_b.ReadData1, v.e1);
        compareValue($sformatf("vec%0d byp_rd2", idx), bus_b.ReadData2, v.e2);
        compareValue($sformatf("vec%0d byp_dbg", idx), bus_b.DbgData, v.ed);
        compareValue($sformatf("vec%0d nob_rd1", idx), bus_n.ReadData1, v.n1);
        compareValue($sformatf("vec%0d nob_rd2", idx), bus_n.ReadData2, v.n2);
        compareValue($sformatf("vec%0d nob_dbg", idx), bus_n.DbgData, v.ed);
        compareValue($sformatf("vec%0d byp_cnt", idx), 32'(bus_b.WrCount), 32'(v.cnt));
        compareValue($sformatf("vec%0d nob_cnt", idx), 32'(bus_n.WrCount), 32'(v.cnt));
    endtask

    initial begin
        tests = 0;
        fails = 0;

        //            we    wr     wd            r1     r2     dbg    e1            e2            ed            n1            n2            cnt
        vecs[0] = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        16'd0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd8,  5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
        vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd8,  5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        32'hDEADBEEF, 16'd1};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        16'd1};
        vecs[4] = '{1'b1, 5'd9,  32'hA5A5A5A5, 5'd8,  5'd9,  5'd9,  32'hDEADBEEF, 32'hA5A5A5A5, 32'h0,        32'hDEADBEEF, 32'h0,        16'd1};
        vecs[5] = '{1'b1, 5'd9,  32'h5A5A5A5A, 5'd9,  5'd9,  5'd9,  32'h5A5A5A5A, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 16'd2};
        vecs[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd9,  5'd31, 32'hFFFFFFFF, 32'h5A5A5A5A, 32'h0,        32'h0,        32'h5A5A5A5A, 16'd3};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd8,  5'd31, 32'hFFFFFFFF, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hDEADBEEF, 16'd4};
        vecs[8] = '{1'b1, 5'd8,  32'h0,        5'd8,  5'd31, 5'd8,  32'h0,        32'hFFFFFFFF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFF, 16'd4};
        vecs[9] = '{1'b0, 5'd0,  32'h0,        5'd8,  5'd8,  5'd8,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        16'd5};

        // Reset asserted with a write pending: nothing forwards, nothing commits.
        rst_n = 1'b0;
        driveBoth(1'b1, 5'd5, 32'h11111111, 5'd5, 5'd5, 5'd5);
        @(posedge clk);
        #1;
        compareValue("in_reset byp_rd1", bus_b.ReadData1, 32'h0);
        compareValue("in_reset byp_rd2", bus_b.ReadData2, 32'h0);
        compareValue("in_reset cnt", 32'(bus_b.WrCount), 32'h0);
        @(negedge clk);
        driveBoth(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        rst_n = 1'b1;

        // Every index reads zero on every port after reset.
        for (int i = 0; i < 32; i++) begin
            driveBoth(1'b0, 5'd0, 32'h0, 5'(i), 5'(i), 5'(i));
            #1;
            if (bus_b.ReadData1 !== 32'h0 || bus_b.ReadData2 !== 32'h0 || bus_b.DbgData !== 32'h0 ||
                bus_n.ReadData1 !== 32'h0 || bus_n.ReadData2 !== 32'h0 || bus_n.DbgData !== 32'h0) begin
                $display("[TB] FAIL reset_read r%0d: got %h/%h/%h expected 0", i,
                         bus_b.ReadData1, bus_b.ReadData2, bus_b.DbgData);
                fails++;
            end
            tests++;
        end
        compareValue("reset cnt", 32'(bus_b.WrCount), 32'h0);

        // Table-driven vectors: drive after a rising edge, check at the falling edge.
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(i);
            @(posedge clk);
            #1;
        end

        // r31 holds all ones; an asynchronous reset between edges clears it at once.
        driveBoth(1'b0, 5'd0, 32'h0, 5'd31, 5'd31, 5'd31);
        #1;
        compareValue("pre_async r31", bus_n.ReadData1, 32'hFFFFFFFF);
        #1;
        rst_n = 1'b0;
        #1;
        compareValue("async r31 byp", bus_b.ReadData1, 32'h0);
        compareValue("async r31 nob", bus_n.ReadData2, 32'h0);
        compareValue("async r31 dbg", bus_n.DbgData, 32'h0);
        compareValue("async cnt", 32'(bus_n.WrCount), 32'h0);

        // A write on an edge while reset is held is ignored.
        driveBoth(1'b1, 5'd31, 32'h00001234, 5'd31, 5'd31, 5'd31);
        #1;
        compareValue("reset_write fwd", bus_b.ReadData1, 32'h0);
        @(posedge clk);
        #1;
        compareValue("reset_write r31", bus_n.ReadData1, 32'h0);
        compareValue("reset_write cnt", 32'(bus_n.WrCount), 32'h0);

        // First write after release commits on the first rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        driveBoth(1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd31, 5'd31);
        #1;
        compareValue("release fwd", bus_b.ReadData1, 32'hCAFEF00D);
        compareValue("release pre", bus_n.ReadData1, 32'h0);
        @(posedge clk);
        #1;
        driveBoth(1'b0, 5'd0, 32'h0, 5'd31, 5'd31, 5'd31);
        #1;
        compareValue("release commit", bus_n.ReadData1, 32'hCAFEF00D);
        compareValue("release cnt", 32'(bus_n.WrCount), 32'h1);

        // 65536 writes to r1 from a clean reset: WrCount wraps to zero.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 65536; i++) begin
            driveBoth(1'b1, 5'd1, 32'(i + 1), 5'd1, 5'd1, 5'd1);
            @(posedge clk);
            #1;
            if (i == 65534) begin
                compareValue("wrap cnt_ffff", 32'(bus_b.WrCount), 32'h0000FFFF);
            end
        end
        driveBoth(1'b0, 5'd0, 32'h0, 5'd1, 5'd1, 5'd1);
        #1;
        compareValue("wrap cnt_zero", 32'(bus_b.WrCount), 32'h0);
        compareValue("wrap r1", bus_b.ReadData1, 32'h00010000);
        compareValue("wrap r1 dbg", bus_n.DbgData, 32'h00010000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
